alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: PRIO_FIXED, default 0, 1 = requester 0 always wins contested lanes, 0 = per-lane round-robin.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 reqN_valid  input  1  requester N (N=0,1) presents an operation.
REQ-005 reqN_ready  output  1  operation of requester N accepted this cycle.
REQ-006 reqN_lane  input  1  0 = lane A (add/sub/and/xor/or), 1 = lane B (sll/slt(u)/sr(a/l)/pass-b).
REQ-007 reqN_op  input  2  lane op code, same encoding as shared ALU.
REQ-008 reqN_alt  input  1  alt flag (sub, unsigned compare, arithmetic shift).
REQ-009 reqN_a, reqN_b  input  32  operands.
REQ-010 rspN_valid  output  1  result for requester N held in response register.
REQ-011 rspN_ready  input  1  requester N consumes result.
REQ-012 rspN_data  output  32  result.

Function
REQ-013 Block SHALL share one existing dual-lane ALU between two requesters; up to one grant per lane per cycle, so two grants per cycle when requesters target different lanes.
REQ-014 slot_free_N = !rspN_valid || rspN_ready; eligible_N = reqN_valid && slot_free_N.
REQ-015 Eligible requester alone on its lane SHALL be granted same cycle.
REQ-016 Both eligible on same lane: PRIO_FIXED=1 grants requester 0; else grants requester named by ptr[lane].
REQ-017 After any grant on lane L, ptr[L] SHALL become the non-granted requester index (round-robin mode only).
REQ-018 reqN_ready SHALL equal grant_N, combinational; depends on reqN_valid, never asserted while reqN_valid low.
REQ-019 Requester not granted SHALL hold its request stable; block SHALL not drop or reorder it.
REQ-020 Unused ALU lane inputs SHALL be driven to zero (a, b, op, alt).
REQ-021 Latency: grant in cycle T -> rspN_valid=1 and rspN_data=ALU result in cycle T+1.
REQ-022 Response register: load on grant; else clear rspN_valid when rspN_ready; else hold value and data.
REQ-023 Simultaneous drain and grant same cycle SHALL load new result with rspN_valid staying 1 (full throughput, one op/cycle/requester).
REQ-024 rspN_ready with rspN_valid=0 SHALL be ignored.
REQ-025 Arithmetic: 32-bit wrap on add/sub; shift amount b[4:0]; compare result zero-extended to 32 bits; lane B op 3 returns b.
REQ-026 Lane-A and lane-B results SHALL route only to the requester granted on that lane.

Reset
REQ-027 While rst_n=0 at a clock edge: rsp0_valid=rsp1_valid=0, rsp0_data=rsp1_data=0, ptr[0]=ptr[1]=0 (requester 0 favoured).
REQ-028 reqN_ready SHALL be 0 during reset cycles; a request in flight at reset is discarded, no response produced.

Structure
REQ-029 Lane op-code constants (ADD, AND, XOR, OR, SLL, SLT, SR, PASSB) and lane enum SHALL live in the shared ALU package.
REQ-030 Block SHALL instantiate the existing shared ALU as its single sub-module; arbitration and response registers remain in alu_arbiter.

Verification
REQ-031 req0 lane0 op0 a=5 b=3, req1 lane1 op0 a=1 b=4, both ready -> both granted T, rsp0_data=8, rsp1_data=16 at T+1.
REQ-032 Both lane0 every cycle, round-robin, rsp ready high -> grants alternate 0,1,0,1 starting with 0 after reset.
REQ-033 req0 lane1 op2 alt=1 a=0x80000000 b=4 -> rsp0_data=0xF8000000; alt=0 -> 0x08000000.
REQ-034 rsp0_ready=0 with rsp0_valid=1, req0 valid -> req0_ready=0, rsp0_data held; raise rsp0_ready -> grant same cycle, new result next cycle, rsp0_valid never drops.
REQ-035 req1 lane1 op1 alt=1 a=0xFFFFFFFF b=1 -> rsp1_data=0 (unsigned); alt=0 -> 1 (signed).
REQ-036 Assert rst_n=0 the cycle after a grant -> rsp valid=0, data=0, ptrs=0 next cycle; PRIO_FIXED=1 contested lane -> requester 0 granted every cycle.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the dual-lane ALU and its two-requester arbiter.
// Provides the lane enum, the per-lane op-code constants, and the per-lane
// grant decision used by alu_arbiter.
package alu_arbiter_pkg;

  typedef enum logic {
    LaneA = 1'b0,  // add/sub, and, xor, or
    LaneB = 1'b1   // sll, slt(u), srl/sra, pass-b
  } lane_e;

  // Lane A op codes
  localparam logic [1:0] OpAdd   = 2'd0;  // alt selects subtract
  localparam logic [1:0] OpAnd   = 2'd1;
  localparam logic [1:0] OpXor   = 2'd2;
  localparam logic [1:0] OpOr    = 2'd3;

  // Lane B op codes
  localparam logic [1:0] OpSll   = 2'd0;
  localparam logic [1:0] OpSlt   = 2'd1;  // alt selects unsigned compare
  localparam logic [1:0] OpSr    = 2'd2;  // alt selects arithmetic shift
  localparam logic [1:0] OpPassB = 2'd3;

  // Grant vector {grant1, grant0} for one lane. On contention the fixed
  // priority picks requester 0, otherwise the favoured index wins.
  function automatic logic [1:0] lane_grant(input logic cand0, input logic cand1,
                                            input logic favoured, input logic fixed);
    logic [1:0] grant;
    if (cand0 && cand1) begin
      grant = (fixed || !favoured) ? 2'b01 : 2'b10;
    end else begin
      grant = {cand1, cand0};
    end
    return grant;
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Shared dual-lane ALU, purely combinational.
// Lane A: add/sub, and, xor, or.  Lane B: sll, slt/sltu, srl/sra, pass-b.
// Ports: lane_a_{a,b,op,alt} -> lane_a_res, lane_b_{a,b,op,alt} -> lane_b_res.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
(
  input  logic [31:0] lane_a_a,
  input  logic [31:0] lane_a_b,
  input  logic [1:0]  lane_a_op,
  input  logic        lane_a_alt,
  output logic [31:0] lane_a_res,
  input  logic [31:0] lane_b_a,
  input  logic [31:0] lane_b_b,
  input  logic [1:0]  lane_b_op,
  input  logic        lane_b_alt,
  output logic [31:0] lane_b_res
);

  logic [4:0] shamt;
  logic       less;

  assign shamt = lane_b_b[4:0];
  assign less  = lane_b_alt ? (lane_b_a < lane_b_b)
                            : ($signed(lane_b_a) < $signed(lane_b_b));

  always_comb begin
    lane_a_res = '0;
    case (lane_a_op)
      OpAdd:   lane_a_res = lane_a_alt ? (lane_a_a - lane_a_b) : (lane_a_a + lane_a_b);
      OpAnd:   lane_a_res = lane_a_a & lane_a_b;
      OpXor:   lane_a_res = lane_a_a ^ lane_a_b;
      default: lane_a_res = lane_a_a | lane_a_b;
    endcase
  end

  always_comb begin
    lane_b_res = '0;
    case (lane_b_op)
      OpSll:   lane_b_res = lane_b_a << shamt;
      OpSlt:   lane_b_res = {31'b0, less};
      OpSr:    lane_b_res = lane_b_alt ? 32'($signed(lane_b_a) >>> shamt) : (lane_b_a >> shamt);
      default: lane_b_res = lane_b_b;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of the shared dual-lane ALU.
// Each lane grants at most one requester per cycle, so two ops can issue
// together when they target different lanes. Results land in a per-requester
// response register one cycle after the grant.
// Ports: clk, rst_n (sync, active-low); reqN_{valid,ready,lane,op,alt,a,b}
// request side; rspN_{valid,ready,data} response side (N = 0, 1).
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter bit PRIO_FIXED = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_lane,
  input  logic [1:0]  req0_op,
  input  logic        req0_alt,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_data,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_lane,
  input  logic [1:0]  req1_op,
  input  logic        req1_alt,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_data
);

  logic        elig0, elig1;
  logic [1:0]  grant_a, grant_b;  // {req1, req0} per lane
  logic        grant0, grant1;
  logic [1:0]  ptr_q, ptr_d;      // favoured requester per lane
  logic        rsp0_valid_q, rsp1_valid_q;
  logic [31:0] rsp0_data_q, rsp1_data_q;

  logic [31:0] la_a, la_b, lb_a, lb_b, la_res, lb_res;
  logic [1:0]  la_op, lb_op;
  logic        la_alt, lb_alt;

  // rst_n gating keeps ready low during reset so nothing is accepted then.
  assign elig0 = rst_n && req0_valid && (!rsp0_valid_q || rsp0_ready);
  assign elig1 = rst_n && req1_valid && (!rsp1_valid_q || rsp1_ready);

  assign grant_a = lane_grant(elig0 && (req0_lane == LaneA), elig1 && (req1_lane == LaneA),
                              ptr_q[0], PRIO_FIXED);
  assign grant_b = lane_grant(elig0 && (req0_lane == LaneB), elig1 && (req1_lane == LaneB),
                              ptr_q[1], PRIO_FIXED);

  assign grant0     = grant_a[0] | grant_b[0];
  assign grant1     = grant_a[1] | grant_b[1];
  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // After a grant the loser becomes favoured; grant[0] is 1 exactly when
  // requester 0 won, which makes requester 1 favoured.
  always_comb begin
    ptr_d = ptr_q;
    if (!PRIO_FIXED) begin
      if (grant_a != 2'b00) ptr_d[0] = grant_a[0];
      if (grant_b != 2'b00) ptr_d[1] = grant_b[0];
    end
  end

  // Idle lanes see all-zero operands.
  always_comb begin
    la_a = '0;
    la_b = '0;
    la_op = '0;
    la_alt = 1'b0;
    if (grant_a[0]) begin
      la_a = req0_a;
      la_b = req0_b;
      la_op = req0_op;
      la_alt = req0_alt;
    end else if (grant_a[1]) begin
      la_a = req1_a;
      la_b = req1_b;
      la_op = req1_op;
      la_alt = req1_alt;
    end
  end

  always_comb begin
    lb_a = '0;
    lb_b = '0;
    lb_op = '0;
    lb_alt = 1'b0;
    if (grant_b[0]) begin
      lb_a = req0_a;
      lb_b = req0_b;
      lb_op = req0_op;
      lb_alt = req0_alt;
    end else if (grant_b[1]) begin
      lb_a = req1_a;
      lb_b = req1_b;
      lb_op = req1_op;
      lb_alt = req1_alt;
    end
  end

  alu_arbiter_alu u_alu (
    .lane_a_a   (la_a),
    .lane_a_b   (la_b),
    .lane_a_op  (la_op),
    .lane_a_alt (la_alt),
    .lane_a_res (la_res),
    .lane_b_a   (lb_a),
    .lane_b_b   (lb_b),
    .lane_b_op  (lb_op),
    .lane_b_alt (lb_alt),
    .lane_b_res (lb_res)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q        <= '0;
      rsp0_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_valid_q <= 1'b0;
      rsp1_data_q  <= '0;
    end else begin
      ptr_q <= ptr_d;
      // A grant wins over a drain so back-to-back ops keep valid high.
      if (grant0) begin
        rsp0_valid_q <= 1'b1;
        rsp0_data_q  <= (req0_lane == LaneB) ? lb_res : la_res;
      end else if (rsp0_ready) begin
        rsp0_valid_q <= 1'b0;
      end
      if (grant1) begin
        rsp1_valid_q <= 1'b1;
        rsp1_data_q  <= (req1_lane == LaneB) ? lb_res : la_res;
      end else if (rsp1_ready) begin
        rsp1_valid_q <= 1'b0;
      end
    end
  end

  assign rsp0_valid = rsp0_valid_q;
  assign rsp0_data  = rsp0_data_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp1_data  = rsp1_data_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a round-robin instance and a fixed-priority instance
// share the same stimulus. A behavioural model checks both every cycle and
// directed literal checks pin the model's arithmetic and arbitration.
module tb_alu_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [1:0]       req_valid, req_lane, req_alt, rsp_ready;
  logic [1:0][1:0]  req_op;
  logic [1:0][31:0] req_a, req_b;

  // [instance][requester]; instance 0 = round-robin, 1 = fixed priority
  logic [1:0][1:0]        ready, rvalid;
  logic [1:0][1:0][31:0]  rdata;

  int tests = 0;
  int fails = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    alu_arbiter #(.PRIO_FIXED(g == 1)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req_valid[0]),
      .req0_ready (ready[g][0]),
      .req0_lane  (req_lane[0]),
      .req0_op    (req_op[0]),
      .req0_alt   (req_alt[0]),
      .req0_a     (req_a[0]),
      .req0_b     (req_b[0]),
      .rsp0_valid (rvalid[g][0]),
      .rsp0_ready (rsp_ready[0]),
      .rsp0_data  (rdata[g][0]),
      .req1_valid (req_valid[1]),
      .req1_ready (ready[g][1]),
      .req1_lane  (req_lane[1]),
      .req1_op    (req_op[1]),
      .req1_alt   (req_alt[1]),
      .req1_a     (req_a[1]),
      .req1_b     (req_b[1]),
      .rsp1_valid (rvalid[g][1]),
      .rsp1_ready (rsp_ready[1]),
      .rsp1_data  (rdata[g][1])
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU: what each lane op means arithmetically.
  function automatic logic [31:0] ref_alu(input logic lane, input logic [1:0] op,
                                          input logic alt, input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    if (!lane) begin
      if (op == 0) return alt ? a - b : a + b;
      if (op == 1) return a & b;
      if (op == 2) return a ^ b;
      return a | b;
    end
    if (op == 0) return a << sh;
    if (op == 1) return alt ? ((a < b) ? 32'd1 : 32'd0)
                            : (($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
    if (op == 2) return alt ? 32'($signed(a) >>> sh) : a >> sh;
    return b;
  endfunction

  // Model state: [instance][requester] response, [instance][lane] favoured requester
  logic        m_rv  [2][2];
  logic [31:0] m_rd  [2][2];
  int          m_fav [2][2];

  initial begin : compare
    bit          started;
    logic [1:0]  want, grant;
    int          win;
    started = 0;
    forever begin
      @(negedge clk);
      if (started) begin
        for (int i = 0; i < 2; i++) begin
          grant = 2'b00;
          if (rst_n) begin
            for (int l = 0; l < 2; l++) begin
              for (int r = 0; r < 2; r++)
                want[r] = req_valid[r] && (req_lane[r] == l[0]) && (!m_rv[i][r] || rsp_ready[r]);
              if (want != 2'b00) begin
                if (want == 2'b11) win = (i == 1) ? 0 : m_fav[i][l];
                else win = want[1] ? 1 : 0;
                grant[win] = 1'b1;
                if (i == 0) m_fav[i][l] = 1 - win;
              end
            end
          end
          for (int r = 0; r < 2; r++) begin
            chk($sformatf("m%0d ready%0d", i, r), 32'(ready[i][r]), 32'(grant[r]));
            chk($sformatf("m%0d rsp_valid%0d", i, r), 32'(rvalid[i][r]), 32'(m_rv[i][r]));
            chk($sformatf("m%0d rsp_data%0d", i, r), rdata[i][r], m_rd[i][r]);
            if (grant[r]) begin
              m_rv[i][r] = 1'b1;
              m_rd[i][r] = ref_alu(req_lane[r], req_op[r], req_alt[r], req_a[r], req_b[r]);
            end else if (rsp_ready[r]) begin
              m_rv[i][r] = 1'b0;
            end
          end
        end
      end
      if (!rst_n) begin
        for (int i = 0; i < 2; i++)
          for (int r = 0; r < 2; r++) begin
            m_rv[i][r] = 1'b0;
            m_rd[i][r] = '0;
            m_fav[i][r] = 0;
          end
        started = 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int r, input logic v, input logic lane, input logic [1:0] op,
                       input logic alt, input logic [31:0] a, input logic [31:0] b);
    req_valid[r] = v;
    req_lane[r]  = lane;
    req_op[r]    = op;
    req_alt[r]   = alt;
    req_a[r]     = a;
    req_b[r]     = b;
  endtask

  initial begin : stimulus
    rst_n = 1'b0;
    rsp_ready = 2'b11;
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    step();
    step();
    chk("reset rsp0_valid", 32'(rvalid[0][0]), 0);
    chk("reset rsp1_data", rdata[0][1], 0);
    rst_n = 1'b1;

    // Different lanes: both granted together.
    drive(0, 1, 0, 2'd0, 0, 32'd5, 32'd3);
    drive(1, 1, 1, 2'd0, 0, 32'd1, 32'd4);
    #1;
    chk("dual ready0", 32'(ready[0][0]), 1);
    chk("dual ready1", 32'(ready[0][1]), 1);
    step();
    chk("dual rsp0_data", rdata[0][0], 32'd8);
    chk("dual rsp1_data", rdata[0][1], 32'd16);
    chk("dual rsp1_valid", 32'(rvalid[0][1]), 1);

    // Reset the cycle after a grant, with requests still presented.
    rst_n = 1'b0;
    drive(0, 1, 0, 2'd0, 0, 32'd100, 32'd1);
    drive(1, 1, 0, 2'd0, 0, 32'd200, 32'd2);
    #1;
    chk("reset ready0", 32'(ready[0][0]), 0);
    step();
    chk("post-reset rsp0_valid", 32'(rvalid[0][0]), 0);
    chk("post-reset rsp0_data", rdata[0][0], 0);
    chk("post-reset rsp1_data", rdata[0][1], 0);
    rst_n = 1'b1;

    // Contested lane A: round-robin alternates from 0, fixed always picks 0.
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr ready0", 32'(ready[0][0]), 32'(k % 2 == 0));
      chk("rr ready1", 32'(ready[0][1]), 32'(k % 2 == 1));
      chk("fixed ready0", 32'(ready[1][0]), 1);
      chk("fixed ready1", 32'(ready[1][1]), 0);
      step();
      if (k % 2 == 0) chk("rr data0", rdata[0][0], 32'd101);
      else chk("rr data1", rdata[0][1], 32'd202);
    end
    drive(1, 0, 0, 0, 0, 0, 0);

    // Right shifts.
    drive(0, 1, 1, 2'd2, 1, 32'h8000_0000, 32'd4);
    step();
    chk("sra", rdata[0][0], 32'hF800_0000);
    drive(0, 1, 1, 2'd2, 0, 32'h8000_0000, 32'd4);
    step();
    chk("srl", rdata[0][0], 32'h0800_0000);
    drive(0, 1, 0, 2'd0, 1, 32'd5, 32'd7);
    step();
    chk("sub wrap", rdata[0][0], 32'hFFFF_FFFE);
    drive(0, 0, 0, 0, 0, 0, 0);

    // Compares on requester 1.
    drive(1, 1, 1, 2'd1, 1, 32'hFFFF_FFFF, 32'd1);
    step();
    chk("sltu", rdata[0][1], 32'd0);
    drive(1, 1, 1, 2'd1, 0, 32'hFFFF_FFFF, 32'd1);
    step();
    chk("slt", rdata[0][1], 32'd1);
    drive(1, 1, 1, 2'd3, 0, 32'd9, 32'h1234_5678);
    step();
    chk("passb", rdata[0][1], 32'h1234_5678);
    drive(1, 0, 0, 0, 0, 0, 0);
    step();

    // Backpressure on response 0, then drain and grant in the same cycle.
    rsp_ready[0] = 1'b0;
    drive(0, 1, 0, 2'd0, 0, 32'd10, 32'd20);
    step();
    chk("bp first data", rdata[0][0], 32'd30);
    drive(0, 1, 0, 2'd0, 0, 32'd1, 32'd1);
    #1;
    chk("bp ready0 low", 32'(ready[0][0]), 0);
    step();
    chk("bp data held", rdata[0][0], 32'd30);
    chk("bp valid held", 32'(rvalid[0][0]), 1);
    rsp_ready[0] = 1'b1;
    #1;
    chk("drain ready0", 32'(ready[0][0]), 1);
    step();
    chk("drain new data", rdata[0][0], 32'd2);
    chk("drain valid kept", 32'(rvalid[0][0]), 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
